// File: rtl/staff_pkg.sv
// Types and constants shared by the staff writer blocks: note encoding, page size, scheduler states.
package staff_pkg;

  localparam int SLOTS  = 160;
  localparam int NOTE_W = 6;
  localparam int PTR_W  = 8;

  typedef logic [NOTE_W-1:0] note_t;

  localparam note_t NOTE_REST = 6'b000000;

  typedef enum logic [1:0] {
    FILL,
    HOLD,
    CLEAR
  } sched_state_t;

endpackage

// File: rtl/frame_strobe.sv
// Single-cycle strobe at pixel (0, COMMIT_LINE) of each frame; purely combinational, no backpressure.
module frame_strobe #(
  parameter int HCOUNT_W    = 11,
  parameter int VCOUNT_W    = 10,
  parameter int COMMIT_LINE = 600
) (
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  output logic                strobe_out
);

  assign strobe_out = (vcount_in == VCOUNT_W'(COMMIT_LINE)) && (hcount_in == '0);

endmodule

// File: rtl/staff_scheduler.sv
// Packs incoming notes into a working page and copies it to the display buffer only on the commit line.
// Commit lands one edge after the strobe cycle; notes are refused (ready low) while a full page is held or wiped.
module staff_scheduler
  import staff_pkg::*;
#(
  parameter int COMMIT_LINE = 600,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                    pixel_clk_in,
  input  logic                    rst_in,
  input  logic [10:0]             hcount_in,
  input  logic [9:0]              vcount_in,
  input  note_t                   note_in,
  input  logic                    note_valid_in,
  output logic                    note_ready_out,
  input  logic                    clear_in,
  output note_t [SLOTS-1:0]       notes_out,
  output logic [PTR_W-1:0]        write_ptr_out,
  output logic                    page_full_out,
  output logic                    commit_out
);

  localparam int               CNT_W     = $clog2(HOLD_FRAMES + 1);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(SLOTS - 1);

  sched_state_t       state_q;
  logic               ready_q;
  logic               full_q;
  logic               dirty_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   clr_ptr_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  note_t [SLOTS-1:0]  work_q;
  note_t [SLOTS-1:0]  disp_q;
  logic               commit_q;

  logic strobe;
  logic handshake;
  logic commit_d;

  frame_strobe #(
    .HCOUNT_W    (11),
    .VCOUNT_W    (10),
    .COMMIT_LINE (COMMIT_LINE)
  ) u_frame_strobe (
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .strobe_out (strobe)
  );

  assign handshake = note_valid_in & ready_q;

  always_comb begin
    commit_d = strobe && dirty_q && (state_q != CLEAR);
  end

  // Display copy samples the registered page, so a same-cycle write waits for the next strobe.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      disp_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= commit_d;
      if (commit_d) disp_q <= work_q;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= FILL;
      ready_q     <= 1'b1;
      full_q      <= 1'b0;
      dirty_q     <= 1'b0;
      wr_ptr_q    <= '0;
      clr_ptr_q   <= '0;
      frame_cnt_q <= '0;
      work_q      <= '0;
    end else begin
      if (commit_d) dirty_q <= 1'b0;

      if (clear_in) begin
        // Abort wins over any handshake in the same cycle; the offered note is dropped.
        state_q     <= CLEAR;
        ready_q     <= 1'b0;
        full_q      <= 1'b0;
        clr_ptr_q   <= '0;
        wr_ptr_q    <= '0;
        frame_cnt_q <= '0;
      end else begin
        case (state_q)
          FILL: begin
            if (handshake) begin
              work_q[wr_ptr_q] <= note_in;
              wr_ptr_q         <= wr_ptr_q + 1'b1;
              dirty_q          <= 1'b1;
              if (wr_ptr_q == LAST_SLOT) begin
                state_q     <= HOLD;
                ready_q     <= 1'b0;
                full_q      <= 1'b1;
                frame_cnt_q <= '0;
              end
            end
          end
          HOLD: begin
            if (strobe) begin
              if (frame_cnt_q == CNT_W'(HOLD_FRAMES - 1)) begin
                state_q   <= CLEAR;
                full_q    <= 1'b0;
                clr_ptr_q <= '0;
              end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
              end
            end
          end
          CLEAR: begin
            work_q[clr_ptr_q] <= NOTE_REST;
            if (clr_ptr_q == LAST_SLOT) begin
              // Dirty is forced so the next strobe publishes the blank page.
              state_q  <= FILL;
              ready_q  <= 1'b1;
              wr_ptr_q <= '0;
              dirty_q  <= 1'b1;
            end else begin
              clr_ptr_q <= clr_ptr_q + 1'b1;
            end
          end
          default: begin
            state_q <= FILL;
            ready_q <= 1'b1;
            full_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign note_ready_out = ready_q;
  assign page_full_out  = full_q;
  assign write_ptr_out  = wr_ptr_q;
  assign notes_out      = disp_q;
  assign commit_out     = commit_q;

endmodule

// File: tb/tb_staff_scheduler.sv
// Directed bench for staff_scheduler with a page-level reference model checked every cycle.
module tb_staff_scheduler;
  import staff_pkg::*;

  localparam int HOLD = 2;
  localparam int LINE = 600;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [10:0]       hc;
  logic [9:0]        vc;
  note_t             note;
  logic              vld;
  logic              clr;
  logic              ready;
  logic              full;
  logic              commit;
  logic [7:0]        wp;
  note_t [SLOTS-1:0] notes;

  always #5 clk = ~clk;

  staff_scheduler #(
    .COMMIT_LINE (LINE),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst_n),
    .hcount_in      (hc),
    .vcount_in      (vc),
    .note_in        (note),
    .note_valid_in  (vld),
    .note_ready_out (ready),
    .clear_in       (clr),
    .notes_out      (notes),
    .write_ptr_out  (wp),
    .page_full_out  (full),
    .commit_out     (commit)
  );

  // Reference model: page contents and mode, wipe modelled as a countdown then a bulk erase.
  int                m_mode;
  note_t             m_work [SLOTS];
  note_t [SLOTS-1:0] m_disp;
  int                m_wp, m_cnt, m_clear_left;
  bit                m_dirty, m_commit;

  int  checks = 0;
  int  passes = 0;
  bit  checking = 0;
  int  cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_wp = 0; m_cnt = 0; m_clear_left = 0;
    m_dirty = 0; m_commit = 0; m_disp = '0;
    foreach (m_work[i]) m_work[i] = '0;
  endtask

  task automatic model_step();
    bit strobe = (vc == 10'(LINE)) && (hc == 11'd0);
    bit com    = strobe && m_dirty && (m_mode != 2);
    m_commit = com;
    if (com) begin
      for (int i = 0; i < SLOTS; i++) m_disp[i] = m_work[i];
      m_dirty = 0;
    end
    if (clr) begin
      m_mode = 2; m_clear_left = SLOTS; m_wp = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (vld) begin
        m_work[m_wp] = note;
        m_wp++;
        m_dirty = 1;
        if (m_wp == SLOTS) begin m_mode = 1; m_cnt = 0; end
      end
    end else if (m_mode == 1) begin
      if (strobe) begin
        m_cnt++;
        if (m_cnt == HOLD) begin m_mode = 2; m_clear_left = SLOTS; end
      end
    end else begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        foreach (m_work[i]) m_work[i] = '0;
        m_mode = 0; m_wp = 0; m_dirty = 1;
      end
    end
  endtask

  // Non-strobe cycles alternate between near-miss raster positions.
  task automatic step(input logic v, input note_t n, input logic c, input logic s);
    vld = v; note = n; clr = c;
    if (s) begin hc = 11'd0; vc = 10'(LINE); end
    else if (cyc % 2 == 0) begin hc = 11'd0; vc = 10'(LINE - 1); end
    else begin hc = 11'd3; vc = 10'(LINE); end
    cyc++;
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic note_t note_of(input int i);
    return 6'(32 | ((i * 5) % 32));
  endfunction

  function automatic logic all_zero(input note_t [SLOTS-1:0] v, input int from);
    for (int i = from; i < SLOTS; i++) if (v[i] != NOTE_REST) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (checking && rst_n) begin
      chk("ready", 32'(ready), 32'(m_mode == 0));
      chk("write_ptr", 32'(wp), 32'(m_wp));
      chk("page_full", 32'(full), 32'(m_mode == 1));
      chk("commit", 32'(commit), 32'(m_commit));
      checks++;
      if (notes === m_disp) passes++;
      else begin
        for (int i = 0; i < SLOTS; i++)
          if (notes[i] !== m_disp[i]) begin
            $display("FAIL notes_out slot %0d: got %b expected %b at %0t", i, notes[i], m_disp[i], $time);
            break;
          end
      end
    end
  end

  initial begin
    rst_n = 1'b0; vld = 1'b0; note = '0; clr = 1'b0; hc = 11'd5; vc = 10'd100;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;

    // Mid-frame asynchronous reset right after a commit
    step(1, 6'b110001, 0, 0);
    step(1, 6'b100111, 0, 0);
    step(0, '0, 0, 1);
    chk("pre_rst_commit", 32'(commit), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_notes_zero", 32'(all_zero(notes, 0)), 32'd1);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_wp", 32'(wp), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic commit
    step(1, 6'b101001, 0, 0);
    step(1, 6'b100001, 0, 0);
    step(1, 6'b000000, 0, 0);
    chk("t2_wp", 32'(wp), 32'd3);
    step(0, '0, 0, 1);
    chk("t2_commit", 32'(commit), 32'd1);
    chk("t2_slot0", 32'(notes[0]), 32'(6'b101001));
    chk("t2_slot1", 32'(notes[1]), 32'(6'b100001));
    chk("t2_slot2", 32'(notes[2]), 32'd0);
    chk("t2_tail_zero", 32'(all_zero(notes, 3)), 32'd1);
    step(0, '0, 0, 0);
    chk("t2_commit_pulse", 32'(commit), 32'd0);

    // Idle strobe
    step(0, '0, 0, 1);
    chk("t6_idle_commit", 32'(commit), 32'd0);

    // Write on strobe
    step(1, 6'b100101, 0, 0);
    step(1, 6'b110011, 0, 1);
    chk("t5_commit", 32'(commit), 32'd1);
    chk("t5_slot3", 32'(notes[3]), 32'(6'b100101));
    chk("t5_slot4_excl", 32'(notes[4]), 32'd0);
    chk("t5_wp", 32'(wp), 32'd5);
    step(0, '0, 0, 1);
    chk("t5_commit2", 32'(commit), 32'd1);
    chk("t5_slot4_incl", 32'(notes[4]), 32'(6'b110011));

    // Clear mid-fill at write_ptr 37
    for (int i = 5; i < 37; i++) step(1, 6'(32 + i), 0, 0);
    chk("t4_wp37", 32'(wp), 32'd37);
    step(1, 6'b111111, 1, 0);
    chk("t4_ready", 32'(ready), 32'd0);
    chk("t4_wp0", 32'(wp), 32'd0);
    step(0, '0, 0, 1);
    chk("t4_no_commit", 32'(commit), 32'd0);
    chk("t4_slot4_kept", 32'(notes[4]), 32'(6'b110011));
    chk("t4_slot5_kept", 32'(notes[5]), 32'd0);
    repeat (158) step(1, 6'b101010, 0, 0);
    chk("t4_still_clear", 32'(ready), 32'd0);
    step(0, '0, 0, 0);
    chk("t4_ready_back", 32'(ready), 32'd1);
    step(0, '0, 0, 1);
    chk("t4_blank_commit", 32'(commit), 32'd1);
    chk("t4_blank_page", 32'(all_zero(notes, 0)), 32'd1);

    // Full page, hold for two strobes, wipe, blank page
    for (int i = 0; i < SLOTS; i++) begin
      step(1, note_of(i), 0, 0);
      if (i == SLOTS - 2) chk("t3_ready_159", 32'(ready), 32'd1);
    end
    chk("t3_ready_low", 32'(ready), 32'd0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_wp160", 32'(wp), 32'd160);
    step(1, 6'b111111, 0, 0);
    step(1, 6'b111111, 0, 0);
    chk("t3_wp_hold", 32'(wp), 32'd160);
    step(0, '0, 0, 1);
    chk("t3_commit1", 32'(commit), 32'd1);
    chk("t3_slot0", 32'(notes[0]), 32'(6'b100000));
    chk("t3_slot159", 32'(notes[159]), 32'(6'b111011));
    chk("t3_full_s1", 32'(full), 32'd1);
    step(0, '0, 0, 0);
    step(0, '0, 0, 1);
    chk("t3_commit2", 32'(commit), 32'd0);
    chk("t3_full_s2", 32'(full), 32'd0);
    repeat (159) step(0, '0, 0, 0);
    chk("t3_clear_len", 32'(ready), 32'd0);
    step(0, '0, 0, 0);
    chk("t3_ready_back", 32'(ready), 32'd1);
    chk("t3_wp_reset", 32'(wp), 32'd0);
    step(0, '0, 0, 1);
    chk("t3_blank_commit", 32'(commit), 32'd1);
    chk("t3_blank_page", 32'(all_zero(notes, 0)), 32'd1);

    // Clear during CLEAR restarts the wipe
    step(1, 6'b100011, 0, 0);
    step(1, 6'b100110, 0, 0);
    step(0, '0, 1, 0);
    repeat (50) step(0, '0, 0, 0);
    step(0, '0, 1, 0);
    repeat (159) step(0, '0, 0, 0);
    chk("restart_len", 32'(ready), 32'd0);
    step(0, '0, 0, 0);
    chk("restart_done", 32'(ready), 32'd1);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
